// File: rtl/dispatch_unit_pkg.sv
// ----------------------------------------------------------------------------
// dispatch_unit_pkg
// Shared definitions for the decoder and the dispatch stage:
//   - one-hot function-unit select encodings carried on dec_fu_type
//   - dispatch FSM state encoding
//   - legality helper for the function-unit select
// ----------------------------------------------------------------------------
package dispatch_unit_pkg;

    localparam logic [2:0] FU_ALU = 3'b001;
    localparam logic [2:0] FU_LSQ = 3'b010;
    localparam logic [2:0] FU_BRA = 3'b100;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } disp_state_e;

    // A select is legal only when it names exactly one function unit.
    function automatic logic fu_is_onehot(input logic [2:0] fu);
        return (fu == FU_ALU) || (fu == FU_LSQ) || (fu == FU_BRA);
    endfunction

endpackage

// File: rtl/rob_tag_alloc.sv
// ----------------------------------------------------------------------------
// rob_tag_alloc
// Circular ROB tag allocator: head/tail pointers plus an occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   alloc      : allocate the tail entry this cycle (caller guarantees !full)
//   commit     : ROB retired its head entry (ignored while empty)
//   flush      : squash all uncommitted entries (tail snaps to head)
//   tail       : tag handed to the next allocation
//   full       : all ROB_DEPTH entries allocated
// ----------------------------------------------------------------------------
module rob_tag_alloc #(
    parameter  int ROB_DEPTH = 16,
    localparam int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc,
    input  logic             commit,
    input  logic             flush,
    output logic [TAG_W-1:0] tail,
    output logic             full
);

    localparam int               CNT_W    = TAG_W + 1;
    localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ROB_DEPTH);

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] head_nxt;
    logic [CNT_W-1:0] count;
    logic             commit_eff;

    // A commit with nothing allocated is spurious and must not move head.
    assign commit_eff = commit && (count != '0);
    assign head_nxt   = commit_eff ? head + TAG_ONE : head;
    assign full       = (count == CNT_FULL);

    // Pointers wrap naturally because ROB_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            // Tail takes the post-commit head so a same-cycle retire is kept.
            head  <= head_nxt;
            tail  <= head_nxt;
            count <= '0;
        end else begin
            head <= head_nxt;
            if (alloc) begin
                tail <= tail + TAG_ONE;
            end
            case ({alloc, commit_eff})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dispatch_unit.sv
// ----------------------------------------------------------------------------
// dispatch_unit
// Single-entry holding stage between the decoder and the ALU/LSQ/BRA issue
// ports, allocating a ROB tag for every instruction it issues.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   dec_valid/dec_ready        : decoder handshake
//   dec_fu_type                : one-hot {BRA,LSQ,ALU} select
//   dec_rob_we                 : instruction is real and needs a ROB entry
//   dec_payload                : opaque decoded instruction
//   alu/lsq/bra_valid, _ready  : per-FU issue handshake
//   iss_payload, iss_tag       : held instruction and its ROB tag
//   rob_commit, flush          : ROB retire and pipeline squash
//   rob_full                   : no free ROB tag
//   ill_inst                   : one-cycle pulse for a dropped instruction
// ----------------------------------------------------------------------------
module dispatch_unit
    import dispatch_unit_pkg::*;
#(
    parameter  int ROB_DEPTH = 16,
    parameter  int PAYLOAD_W = 64,
    localparam int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic [2:0]           dec_fu_type,
    input  logic                 dec_rob_we,
    input  logic [PAYLOAD_W-1:0] dec_payload,
    output logic                 alu_valid,
    output logic                 lsq_valid,
    output logic                 bra_valid,
    input  logic                 alu_ready,
    input  logic                 lsq_ready,
    input  logic                 bra_ready,
    output logic [PAYLOAD_W-1:0] iss_payload,
    output logic [TAG_W-1:0]     iss_tag,
    input  logic                 rob_commit,
    input  logic                 flush,
    output logic                 rob_full,
    output logic                 ill_inst
);

    disp_state_e            state;
    disp_state_e            state_nxt;
    logic [2:0]             hold_fu_p1;
    logic [PAYLOAD_W-1:0]   hold_payload_p1;
    logic                   sel_ready;
    logic                   fire;
    logic                   accept;
    logic                   legal;
    logic                   load;
    logic                   alloc;
    logic                   ill_nxt;

    assign sel_ready = |(hold_fu_p1 & {bra_ready, lsq_ready, alu_ready});
    assign fire      = (state == HOLD) && sel_ready && !rob_full;
    assign accept    = dec_valid && dec_ready;
    assign legal     = dec_rob_we && fu_is_onehot(dec_fu_type);

    // Flush wins: a concurrent accept or fire still completes the decoder
    // handshake but leaves no trace in the holding register or the ROB.
    assign load      = accept && legal && !flush;
    assign alloc     = fire && !flush;
    assign ill_nxt   = accept && !legal && !flush;

    rob_tag_alloc #(
        .ROB_DEPTH (ROB_DEPTH)
    ) u_alloc (
        .clk    (clk),
        .rst_n  (rst_n),
        .alloc  (alloc),
        .commit (rob_commit),
        .flush  (flush),
        .tail   (iss_tag),
        .full   (rob_full)
    );

    always_comb begin
        state_nxt = state;
        dec_ready = 1'b0;
        alu_valid = 1'b0;
        lsq_valid = 1'b0;
        bra_valid = 1'b0;
        case (state)
            EMPTY: begin
                dec_ready = 1'b1;
                if (load) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                dec_ready = fire;
                alu_valid = |(hold_fu_p1 & FU_ALU);
                lsq_valid = |(hold_fu_p1 & FU_LSQ);
                bra_valid = |(hold_fu_p1 & FU_BRA);
                if (fire && !load) begin
                    state_nxt = EMPTY;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
        if (flush) begin
            state_nxt = FLUSH;
        end
    end

    // ---- decode -> hold (p1) boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            hold_fu_p1 <= '0;
            ill_inst   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ill_inst <= ill_nxt;
            if (load) begin
                hold_fu_p1 <= dec_fu_type;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            hold_payload_p1 <= dec_payload;
        end
    end

    assign iss_payload = hold_payload_p1;

endmodule
